interconn_rx_port: RTL
======================

Name: interconn_rx_port

Overview:
- Per-MVU receive-side buffer sitting directly downstream of the MVU crossbar interconnect.
- Captures one crossbar output lane (recvValid/recvMsg slice i) every cycle it is valid, and queues messages in a FIFO.
- Presents messages to the consuming MVU over a valid/ready handshake.
- Reports occupancy and back-pressure status (full, almostFull, level) and counts messages lost to overflow, so the sender-address scheduler can throttle.

Parameters:
- w, 96, message width in bits; matches crossbar lane width.
- d, 8, FIFO depth in messages; power of two, >= 2.
- af, 6, almostFull threshold; 1 <= af <= d.
- l, $clog2(d+1), localparam; width of the level output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- recvValid  input  1  crossbar lane valid; no ready back to crossbar.
- recvMsg  input  w  crossbar lane message.
- outValid  output  1  head message available.
- outMsg  output  w  head message.
- outReady  input  1  consumer accepts head this cycle.
- full  output  1  level == d.
- almostFull  output  1  level >= af.
- level  output  l  messages currently stored, 0..d.
- dropCount  output  16  saturating count of overflow drops.

Behaviour:
- Reset: rst low at a rising edge clears wrPtr, rdPtr, level and dropCount, and forces outValid=0, full=0, almostFull=0. outMsg is don't-care while outValid=0. Storage contents are not cleared.
- Reset mid-operation: all queued messages are discarded. A recvValid in the reset cycle is ignored and not counted as a drop.
- Write condition: recvValid && (!full || rdFire), where rdFire = outValid && outReady.
- On write, recvMsg is stored at wrPtr and wrPtr increments modulo d.
- Read: on rdFire, rdPtr increments modulo d.
- Output is first-word-fall-through:
  - outValid = (level != 0).
  - outMsg = storage[rdPtr], driven combinationally from registered state.
- Latency: a message written at edge k is visible on outValid/outMsg in the cycle after edge k (1 cycle).
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- Full with simultaneous read: the write is accepted, level stays d, and no drop is recorded.
- Full without read: the message is dropped and dropCount increments.
- Empty: outValid=0, so no read can occur. A write into an empty FIFO appears at the output one cycle later.
- Pointer wrap: rdPtr and wrPtr wrap from d-1 to 0. Full versus empty is distinguished by level, not by pointer equality.
- Order: strict FIFO; the consumer sees messages in exactly crossbar arrival order.
- Flags are derived combinationally from registered level:
  - full = (level == d).
  - almostFull = (level >= af).
- outMsg must hold stable while outValid && !outReady.
- Assertions (simulation only): level never exceeds d; rdFire never occurs when level == 0.

Optional Feature:
- Macro: INTERCONN_RX_DROP_COUNT_EN.
- Defined:
  - dropCount is a 16-bit register, cleared by reset.
  - It increments by 1 on each cycle with recvValid && full && !rdFire.
  - It saturates at 16'hFFFF.
- Undefined:
  - No counter register is built and dropCount is tied to 16'h0000.
  - Drop behaviour is otherwise identical: the message is discarded silently.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then rst=1 with recvValid=0 -> outValid=0, level=0, full=0, almostFull=0, dropCount=0.
- Single pass-through: recvValid=1 with recvMsg=96'hDEAD for one cycle, outReady=0 -> next cycle outValid=1, outMsg=DEAD, level=1. Then outReady=1 for one cycle -> outValid=0, level=0.
- Fill and order (d=8, af=6): write messages 1..8 back-to-back with outReady=0:
  - almostFull rises after the 6th write; full rises after the 8th; level=8.
  - Drain with outReady=1 -> outMsg sequence 1,2,...,8, then outValid=0.
- Overflow: FIFO full with outReady=0, drive 3 more valid messages 9,10,11 -> level stays 8, dropCount=3 (macro defined) or 0 (undefined). Drain yields 1..8 only.
- Full with simultaneous read/write: FIFO full, outReady=1 and recvValid=1 with msg 0xAA in the same cycle -> level stays 8, no drop, and 0xAA emerges last after draining.
- Reset mid-stream with wrap: write 5, read 3, write 6 (pointers wrap), then assert rst=0 for 1 cycle while recvValid=1 -> level=0, outValid=0, dropCount=0, and the next write is the first output seen.

Source files
------------

// File: rtl/interconn_rx_port_if.sv
// -----------------------------------------------------------------------------
// interconn_rx_port_if
//   Bundles the crossbar-lane input, the consumer handshake and the status
//   outputs of one MVU receive port.
//
//   Handshake: one message transfers to the consumer on every rising clk edge
//   where outValid && outReady. outValid never depends on outReady. outMsg
//   holds stable while outValid && !outReady. The crossbar side has no ready
//   signal. A recvValid that meets a full FIFO with no read in the same cycle
//   is dropped.
//
//   Parameters: w = message width, d = FIFO depth (sets the level width).
//   Modports:
//     slave  - the receive port (consumes recv*, outReady; drives out*, status)
//     master - the environment (crossbar lane plus consumer)
// -----------------------------------------------------------------------------
interface interconn_rx_port_if #(
  parameter int w = 96,
  parameter int d = 8
);
  localparam int l = $clog2(d + 1);

  logic         recvValid;
  logic [w-1:0] recvMsg;
  logic         outValid;
  logic [w-1:0] outMsg;
  logic         outReady;
  logic         full;
  logic         almostFull;
  logic [l-1:0] level;
  logic [15:0]  dropCount;

  modport slave (
    input  recvValid, recvMsg, outReady,
    output outValid, outMsg, full, almostFull, level, dropCount
  );

  modport master (
    output recvValid, recvMsg, outReady,
    input  outValid, outMsg, full, almostFull, level, dropCount
  );
endinterface

// File: rtl/interconn_rx_port.sv
// -----------------------------------------------------------------------------
// interconn_rx_port
//   Per-MVU receive buffer downstream of the crossbar. Every cycle the lane is
//   valid its message is pushed into a first-word-fall-through FIFO. The
//   consumer pops the FIFO over a valid/ready handshake. Occupancy status
//   (full, almostFull, level) lets the sender scheduler throttle.
//
//   Ports:
//     clk  - system clock, all state changes on the rising edge
//     rst  - synchronous, active-low reset
//     bus  - interconn_rx_port_if.slave (recv*, out*, full, almostFull,
//            level, dropCount)
//
//   Optional feature, macro INTERCONN_RX_DROP_COUNT_EN:
//     defined   - dropCount is a saturating 16-bit counter of messages lost
//                 to overflow
//     undefined - no counter is built and dropCount reads 16'h0000
// -----------------------------------------------------------------------------
module interconn_rx_port #(
  parameter int w  = 96,
  parameter int d  = 8,
  parameter int af = 6
) (
  input logic                  clk,
  input logic                  rst,
  interconn_rx_port_if.slave   bus
);
  localparam int l  = $clog2(d + 1);
  localparam int pw = (d > 1) ? $clog2(d) : 1;

  localparam logic [l-1:0]  DEPTH_L = l'(d);
  localparam logic [l-1:0]  AF_L    = l'(af);
  localparam logic [l-1:0]  LVL_ONE = l'(1);
  localparam logic [pw-1:0] PTR_ONE = pw'(1);

  logic [w-1:0]  mem_q [d];
  logic [pw-1:0] wr_ptr_q, wr_ptr_d;
  logic [pw-1:0] rd_ptr_q, rd_ptr_d;
  logic [l-1:0]  level_q, level_d;

  logic full_w;
  logic out_valid_w;
  logic rd_fire;
  logic wr_en;

  assign out_valid_w = (level_q != '0);
  assign full_w      = (level_q == DEPTH_L);
  assign rd_fire     = out_valid_w && bus.outReady;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_en       = bus.recvValid && (!full_w || rd_fire);

  // d is a power of two, so natural pointer overflow is the modulo-d wrap.
  always_comb begin
    wr_ptr_d = wr_en   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en, rd_fire})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; level alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_ptr_q] <= bus.recvMsg;
    end
  end

  assign bus.outValid   = out_valid_w;
  assign bus.outMsg     = mem_q[rd_ptr_q];
  assign bus.full       = full_w;
  assign bus.almostFull = (level_q >= AF_L);
  assign bus.level      = level_q;

`ifdef INTERCONN_RX_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (bus.recvValid && full_w && !rd_fire && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= 16'h0000;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.dropCount = drop_q;
`else
  assign bus.dropCount = 16'h0000;
`endif

`ifndef SYNTHESIS
  a_level_max: assert property (@(posedge clk) disable iff (!rst)
    level_q <= DEPTH_L);
  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst)
    rd_fire |-> (level_q != '0));
`endif
endmodule
